hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline controller that sequences the ID/EX buffer and its neighbours. It keeps a
//  two-entry scoreboard of in-flight destinations (EX, MEM) and produces forwarding
//  selects, load-use bubbles, branch flushes and whole-pipe freezes on slow data memory.
//  It sits beside the ID/EX buffer: its outputs drive that buffer's clear and fwd_* inputs
//  and the PC / IF-ID hold enables.
// PARAMETERS
//  FLUSH_CYCLES  2  cycles ID/EX is cleared after a taken branch (1..7)
//  RA_W          5  register-address width
// PORTS
//  clk            in   1     pipeline clock; state updates on rising edge
//  rst            in   1     asynchronous, active-low reset
//  id_valid       in   1     ID holds a real instruction
//  id_rs1,id_rs2  in   RA_W  ID source registers
//  id_use1,id_use2 in  1     instruction reads rs1 / rs2
//  id_rd          in   RA_W  ID destination
//  id_RegWrite    in   1     ID writes rd
//  id_MemRead     in   1     ID is a load
//  id_MemWrite    in   1     ID is a store
//  br_taken       in   1     EX resolved a taken branch/jump (1-cycle pulse)
//  mem_ready      in   1     data memory completes the access in MEM this cycle
//  fwd_ex_1/2     out  1     select EX result for rs1/rs2
//  fwd_mem_1/2    out  1     select MEM result for rs1/rs2
//  stall_pc       out  1     hold PC
//  stall_ifid     out  1     hold IF/ID
//  clear_idex     out  1     insert bubble into ID/EX
//  flush_ifid     out  1     squash IF/ID contents
//  freeze         out  1     hold ID/EX, EX/MEM and MEM/WB
//  mem_req        out  1     MEM stage holds a load/store awaiting completion
// BEHAVIOUR
//  Scoreboard entry = {v, rd, RegWrite, MemRead, MemOp}. Reset: both entries invalid, state RUN,
//   counter 0, every output 0.
//  Advance (no freeze): MEM<=EX; EX<=ID decode, or invalid if clear_idex | !id_valid.
//  Forwarding (combinational, valid in every state): match = v & RegWrite & rd!=0 & rd==rsN & id_useN.
//   fwd_ex_N = EX match & !EX.MemRead; fwd_mem_N = MEM match & !fwd_ex_N (EX wins).
//  Load-use (RUN only): EX match & EX.MemRead -> stall_pc=stall_ifid=clear_idex=1 for exactly
//   1 cycle; the next cycle forwards from MEM.
//  FSM states:
//   RUN: MEM.v & MEM.MemOp & !mem_ready -> MEM_WAIT. Else br_taken -> FLUSH, cnt=FLUSH_CYCLES-1.
//   MEM_WAIT: freeze=stall_pc=stall_ifid=mem_req=1; scoreboard held; br_taken ignored
//    (EX is frozen, so it stays asserted). On mem_ready -> RUN; outputs drop that same cycle.
//   FLUSH: flush_ifid=clear_idex=1. cnt decrements each cycle; cnt==0 -> RUN.
//    A MEM-wait hazard freezes FLUSH in place; cnt holds until mem_ready.
//  Priority: reset > MEM wait > branch flush > load-use. br_taken and a load-use hazard
//   in the same cycle: flush only, no stall_pc.
//  mem_req=1 in RUN when MEM.v & MemOp, independent of mem_ready. With mem_ready=1 there
//   is zero-wait and no state change.
//  rst low mid-operation: immediate return to reset values; no pending flush survives.
//  Latency: hazard outputs are combinational from state plus registered scoreboard. They
//   settle within the high phase, before the buffer's falling-edge capture.
// CONFIGURATION
//  HAZARD_CTRL_PERF_EN defined: adds out [31:0] perf_ld_stalls, perf_mem_wait, perf_flush.
//   Saturating counters; each increments once per cycle spent in that condition.
//   Cleared by rst only.
//  Not defined: these ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  Shared package: state encodings RUN=2'd0, MEM_WAIT=2'd1, FLUSH=2'd2; scoreboard-entry
//   field widths; REG_ZERO=0.
//  One sub-module, hazard_fwd_cmp: pure match/priority logic, instantiated once per
//   source operand. FSM, scoreboard and counters live in hazard_ctrl.
// TESTING
//  addi x5 then add x6,x5,x5 back-to-back -> fwd_ex_1=fwd_ex_2=1; fwd_mem_*=0; no stall.
//  lw x7 then add x8,x7,x0 -> 1 cycle of stall_pc=stall_ifid=clear_idex=1; next cycle
//   fwd_mem_1=1 and fwd_ex_1=0.
//  Writes to x0 followed by a reader of x0 -> all fwd_*=0 and no load-use stall.
//  br_taken pulse with FLUSH_CYCLES=2 -> flush_ifid=clear_idex=1 for exactly 2 cycles,
//   then RUN.
//  sw in MEM with mem_ready low for 3 cycles -> freeze=mem_req=1 for 3 cycles,
//   scoreboard unchanged; release on the 4th cycle.
//  rst asserted mid-FLUSH -> all outputs 0 asynchronously; after release, RUN with empty
//   scoreboard.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared types and constants for the hazard controller
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } hz_state_e;

  // Scoreboard entry flags; the register address is held alongside with RA_W bits
  typedef struct packed {
    logic v;
    logic reg_write;
    logic mem_read;
    logic mem_op;
  } sb_entry_t;

  localparam int SB_FLAG_W = $bits(sb_entry_t);
  localparam int CNT_W     = 3;
  localparam int PERF_W    = 32;
  localparam int REG_ZERO  = 0;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] val);
    return (&val) ? val : val + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_fwd_cmp.sv
// ============================================================================
// Module      : hazard_fwd_cmp
// Description : Per-operand scoreboard match with EX-over-MEM priority
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_fwd_cmp
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] i_rs,
  input  logic            i_use,
  input  logic            i_ex_v,
  input  logic            i_ex_rw,
  input  logic            i_ex_mr,
  input  logic [RA_W-1:0] i_ex_rd,
  input  logic            i_mem_v,
  input  logic            i_mem_rw,
  input  logic [RA_W-1:0] i_mem_rd,
  output logic            o_fwd_ex,
  output logic            o_fwd_mem,
  output logic            o_ld_use
);

  localparam logic [RA_W-1:0] C_RD_ZERO = RA_W'(REG_ZERO);

  logic w_ex_match;
  logic w_mem_match;

  assign w_ex_match  = i_ex_v & i_ex_rw & (i_ex_rd != C_RD_ZERO) & (i_ex_rd == i_rs) & i_use;
  assign w_mem_match = i_mem_v & i_mem_rw & (i_mem_rd != C_RD_ZERO) & (i_mem_rd == i_rs) & i_use;

  // A load in EX cannot forward yet; it is reported as a load-use hazard instead
  assign o_fwd_ex  = w_ex_match & ~i_ex_mr;
  assign o_fwd_mem = w_mem_match & ~o_fwd_ex;
  assign o_ld_use  = w_ex_match & i_ex_mr;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : ID/EX hazard controller: scoreboard, forwarding, stalls,
//               branch flush and memory-wait freeze.
//               Optional HAZARD_CTRL_PERF_EN adds saturating perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int RA_W         = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use1,
  input  logic            id_use2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_RegWrite,
  input  logic            id_MemRead,
  input  logic            id_MemWrite,
  input  logic            br_taken,
  input  logic            mem_ready,
  output logic            fwd_ex_1,
  output logic            fwd_ex_2,
  output logic            fwd_mem_1,
  output logic            fwd_mem_2,
  output logic            stall_pc,
  output logic            stall_ifid,
  output logic            clear_idex,
  output logic            flush_ifid,
  output logic            freeze,
  output logic            mem_req
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_ld_stalls,
  output logic [PERF_W-1:0] perf_mem_wait,
  output logic [PERF_W-1:0] perf_flush
`endif
);

  localparam logic [CNT_W-1:0] C_FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);

  hz_state_e        r_state;
  hz_state_e        w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  sb_entry_t        r_ex;
  sb_entry_t        w_id_entry;
  logic [RA_W-1:0]  r_ex_rd;
  logic             r_mem_v;
  logic             r_mem_rw;
  logic             r_mem_op;
  logic [RA_W-1:0]  r_mem_rd;

  logic w_ld_use_1;
  logic w_ld_use_2;
  logic w_ld_use;
  logic w_mem_busy;
  logic w_mem_hazard;
  logic w_resume;

  hazard_fwd_cmp #(.RA_W(RA_W)) u_fwd1 (
    .i_rs      (id_rs1),
    .i_use     (id_use1),
    .i_ex_v    (r_ex.v),
    .i_ex_rw   (r_ex.reg_write),
    .i_ex_mr   (r_ex.mem_read),
    .i_ex_rd   (r_ex_rd),
    .i_mem_v   (r_mem_v),
    .i_mem_rw  (r_mem_rw),
    .i_mem_rd  (r_mem_rd),
    .o_fwd_ex  (fwd_ex_1),
    .o_fwd_mem (fwd_mem_1),
    .o_ld_use  (w_ld_use_1)
  );

  hazard_fwd_cmp #(.RA_W(RA_W)) u_fwd2 (
    .i_rs      (id_rs2),
    .i_use     (id_use2),
    .i_ex_v    (r_ex.v),
    .i_ex_rw   (r_ex.reg_write),
    .i_ex_mr   (r_ex.mem_read),
    .i_ex_rd   (r_ex_rd),
    .i_mem_v   (r_mem_v),
    .i_mem_rw  (r_mem_rw),
    .i_mem_rd  (r_mem_rd),
    .o_fwd_ex  (fwd_ex_2),
    .o_fwd_mem (fwd_mem_2),
    .o_ld_use  (w_ld_use_2)
  );

  assign w_ld_use     = w_ld_use_1 | w_ld_use_2;
  assign w_mem_busy   = r_mem_v & r_mem_op;
  assign w_mem_hazard = w_mem_busy & ~mem_ready;

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    stall_pc     = 1'b0;
    stall_ifid   = 1'b0;
    clear_idex   = 1'b0;
    flush_ifid   = 1'b0;
    freeze       = 1'b0;
    mem_req      = 1'b0;
    w_resume     = 1'b0;

    case (r_state)
      ST_RUN: begin
        mem_req = w_mem_busy;
        if (w_mem_hazard) begin
          freeze       = 1'b1;
          stall_pc     = 1'b1;
          stall_ifid   = 1'b1;
          w_next_state = ST_MEM_WAIT;
        end else begin
          w_resume = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // EX is frozen, so a pending branch is still asserted on the release cycle
        if (!mem_ready) begin
          freeze     = 1'b1;
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          mem_req    = 1'b1;
        end else begin
          w_next_state = ST_RUN;
          w_resume     = 1'b1;
        end
      end
      ST_FLUSH: begin
        mem_req = w_mem_busy;
        if (w_mem_hazard) begin
          freeze     = 1'b1;
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
        end else begin
          flush_ifid = 1'b1;
          clear_idex = 1'b1;
          if (r_cnt == '0) begin
            w_next_state = ST_RUN;
          end else begin
            w_cnt_next = r_cnt - 1'b1;
          end
        end
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase

    if (w_resume) begin
      if (br_taken) begin
        w_next_state = ST_FLUSH;
        w_cnt_next   = C_FLUSH_INIT;
      end else if (w_ld_use) begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        clear_idex = 1'b1;
      end
    end
  end

  always_comb begin
    w_id_entry           = '0;
    w_id_entry.v         = id_valid & ~clear_idex;
    w_id_entry.reg_write = id_RegWrite;
    w_id_entry.mem_read  = id_MemRead;
    w_id_entry.mem_op    = id_MemRead | id_MemWrite;
    if (!w_id_entry.v) begin
      w_id_entry = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_RUN;
      r_cnt    <= '0;
      r_ex     <= '0;
      r_ex_rd  <= '0;
      r_mem_v  <= 1'b0;
      r_mem_rw <= 1'b0;
      r_mem_op <= 1'b0;
      r_mem_rd <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      if (!freeze) begin
        r_mem_v  <= r_ex.v;
        r_mem_rw <= r_ex.reg_write;
        r_mem_op <= r_ex.mem_op;
        r_mem_rd <= r_ex_rd;
        r_ex     <= w_id_entry;
        r_ex_rd  <= id_rd;
      end
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [PERF_W-1:0] r_perf_ld;
  logic [PERF_W-1:0] r_perf_mw;
  logic [PERF_W-1:0] r_perf_fl;

  // stall_pc together with clear_idex only occurs for a load-use bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_ld <= '0;
      r_perf_mw <= '0;
      r_perf_fl <= '0;
    end else begin
      if (stall_pc & clear_idex) r_perf_ld <= sat_inc(r_perf_ld);
      if (freeze)                r_perf_mw <= sat_inc(r_perf_mw);
      if (flush_ifid)            r_perf_fl <= sat_inc(r_perf_fl);
    end
  end

  assign perf_ld_stalls = r_perf_ld;
  assign perf_mem_wait  = r_perf_mw;
  assign perf_flush     = r_perf_fl;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed-vector bench for hazard_ctrl (FLUSH_CYCLES=2)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int RA_W = 5;

  logic            clk;
  logic            rst;
  logic            id_valid;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic            id_use1;
  logic            id_use2;
  logic [RA_W-1:0] id_rd;
  logic            id_RegWrite;
  logic            id_MemRead;
  logic            id_MemWrite;
  logic            br_taken;
  logic            mem_ready;
  logic            fwd_ex_1, fwd_ex_2, fwd_mem_1, fwd_mem_2;
  logic            stall_pc, stall_ifid, clear_idex, flush_ifid, freeze, mem_req;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0]     perf_ld_stalls, perf_mem_wait, perf_flush;
`endif

  int n_total = 0;
  int n_bad   = 0;

  // {fwd_ex_1, fwd_ex_2, fwd_mem_1, fwd_mem_2, stall_pc, stall_ifid, clear_idex, flush_ifid, freeze, mem_req}
  logic [9:0] w_outs;
  assign w_outs = {fwd_ex_1, fwd_ex_2, fwd_mem_1, fwd_mem_2, stall_pc,
                   stall_ifid, clear_idex, flush_ifid, freeze, mem_req};

  hazard_ctrl #(.FLUSH_CYCLES(2), .RA_W(RA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use1     (id_use1),
    .id_use2     (id_use2),
    .id_rd       (id_rd),
    .id_RegWrite (id_RegWrite),
    .id_MemRead  (id_MemRead),
    .id_MemWrite (id_MemWrite),
    .br_taken    (br_taken),
    .mem_ready   (mem_ready),
    .fwd_ex_1    (fwd_ex_1),
    .fwd_ex_2    (fwd_ex_2),
    .fwd_mem_1   (fwd_mem_1),
    .fwd_mem_2   (fwd_mem_2),
    .stall_pc    (stall_pc),
    .stall_ifid  (stall_ifid),
    .clear_idex  (clear_idex),
    .flush_ifid  (flush_ifid),
    .freeze      (freeze),
    .mem_req     (mem_req)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .perf_ld_stalls (perf_ld_stalls),
    .perf_mem_wait  (perf_mem_wait),
    .perf_flush     (perf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b exp=%b", tag, got[9:0], exp[9:0]);
    end
  endtask

  task automatic set_id(input logic v, input int rs1, input int rs2, input logic u1,
                        input logic u2, input int rd, input logic rw, input logic mr,
                        input logic mw);
    id_valid    = v;
    id_rs1      = RA_W'(rs1);
    id_rs2      = RA_W'(rs2);
    id_use1     = u1;
    id_use2     = u2;
    id_rd       = RA_W'(rd);
    id_RegWrite = rw;
    id_MemRead  = mr;
    id_MemWrite = mw;
  endtask

  task automatic idle();
    set_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Check combinational outputs mid-cycle, then advance to just after the next rising edge
  task automatic cyc(input string tag, input logic [9:0] exp);
    @(negedge clk);
    chk(tag, {22'd0, w_outs}, {22'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    br_taken  = 1'b0;
    mem_ready = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    cyc("reset", 10'b0000000000);
    rst = 1'b1;

    // Back-to-back ALU forwarding, EX priority and use gating
    set_id(1, 0, 0, 1, 0, 5, 1, 0, 0); cyc("fwd_addi",     10'b0000000000);
    set_id(1, 5, 5, 1, 1, 5, 1, 0, 0); cyc("fwd_ex_both",  10'b1100000000);
    set_id(1, 5, 5, 1, 0, 6, 1, 0, 0); cyc("fwd_ex_wins",  10'b1000000000);
    set_id(1, 6, 5, 1, 1, 9, 1, 0, 0); cyc("fwd_ex_mem",   10'b1001000000);
    idle();                            cyc("drain1",       10'b0000000000);
    idle();                            cyc("drain2",       10'b0000000000);

    // Writers of x0 never forward or stall; zero-wait load in MEM only raises mem_req
    set_id(1, 0, 0, 1, 0, 0, 1, 0, 0); cyc("x0_addi",      10'b0000000000);
    set_id(1, 0, 0, 1, 0, 0, 1, 1, 0); cyc("x0_lw",        10'b0000000000);
    set_id(1, 0, 0, 1, 1, 3, 1, 0, 0); cyc("x0_read",      10'b0000000000);
    idle();                            cyc("x0_memreq",    10'b0000000001);
    idle();                            cyc("drain3",       10'b0000000000);

    // lw x7 ; add x8,x7,x0
    set_id(1, 0, 0, 1, 0, 7, 1, 1, 0); cyc("lu_lw",        10'b0000000000);
    set_id(1, 7, 0, 1, 1, 8, 1, 0, 0); cyc("lu_stall",     10'b0000111000);
    cyc("lu_fwd_mem", 10'b0010000001);
    idle();                            cyc("lu_after",     10'b0000000000);

    // Branch coinciding with a load-use hazard, then a 2-cycle flush
    set_id(1, 0, 0, 1, 0, 7, 1, 1, 0); cyc("br_lw",        10'b0000000000);
    set_id(1, 7, 0, 1, 0, 8, 1, 0, 0); br_taken = 1'b1;
    cyc("br_lu_same", 10'b0000000000);
    br_taken = 1'b0; idle();           cyc("flush_1",      10'b0000001101);
    cyc("flush_2",    10'b0000001100);
    cyc("flush_done", 10'b0000000000);

    // sw in MEM with three wait cycles; br_taken during the wait is ignored
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1); cyc("mw_sw",        10'b0000000000);
    set_id(1, 0, 0, 0, 0, 3, 1, 0, 0); cyc("mw_addi",      10'b0000000000);
    set_id(1, 3, 0, 1, 0, 0, 0, 0, 0); mem_ready = 1'b0;
    cyc("mw_1", 10'b1000110011);
    br_taken = 1'b1;
    cyc("mw_2", 10'b1000110011);
    br_taken = 1'b0;
    cyc("mw_3", 10'b1000110011);
    mem_ready = 1'b1;
    cyc("mw_release", 10'b1000000000);
    cyc("mw_after",   10'b0010000000);

    // Reset asserted in the middle of a flush
    idle(); br_taken = 1'b1;           cyc("rf_br",        10'b0000000000);
    br_taken = 1'b0;
    @(negedge clk);
    chk("rf_flush", {22'd0, w_outs}, {22'd0, 10'b0000001100});
    #2 rst = 1'b0;
    #1 chk("rf_async", {22'd0, w_outs}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    set_id(1, 3, 0, 1, 0, 4, 1, 0, 0); cyc("rf_post1",     10'b0000000000);
    set_id(1, 4, 0, 1, 0, 0, 0, 0, 0); cyc("rf_post2",     10'b1000000000);
    idle();                            cyc("rf_post3",     10'b0000000000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
